// File: rtl/sr_ff_bank.sv
// -----------------------------------------------------------------------------
// sr_ff_bank
//
// Bank of WIDTH edge-triggered flip-flops sharing one clock. A run-time mode
// select picks the per-channel next-state function (SR, JK, D or T), and a
// common enable gates every update. In SR mode the forbidden input (s=r=1)
// is detected per channel. It sets a sticky per-channel flag and adds to a
// saturating event counter.
//
// There is no handshake: every input is sampled on each rising edge of clk,
// and every output is a register (or the inverse of one), one cycle later.
//
// Parameters
//   WIDTH   : number of channels (1..32)
//   CNT_W   : width of the forbidden-event counter
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   en       in   update enable for the channel state (0 = hold)
//   mode     in   00=SR, 01=JK, 10=D, 11=T (applies to all channels)
//   s        in   per-channel S / J / D / T input
//   r        in   per-channel R / K input (ignored in D and T modes)
//   clr_err  in   clears err and err_cnt (works regardless of en)
//   q        out  channel state
//   q_bar    out  always ~q
//   err      out  sticky per-channel SR forbidden-input flag
//   err_cnt  out  saturating count of forbidden events
// -----------------------------------------------------------------------------
module sr_ff_bank #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [1:0] MODE_SR = 2'b00;
   localparam logic [1:0] MODE_JK = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_T  = 2'b11;

   // The adder must hold the counter plus a popcount of up to 32 (6 bits)
   // without overflowing, whatever CNT_W is.
   localparam int SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [WIDTH-1:0] q_q,   q_d;
   logic [WIDTH-1:0] err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] forbid;
   logic [5:0]       pop;
   logic [WIDTH-1:0] err_base;
   logic [CNT_W-1:0] cnt_base;
   logic [SUM_W-1:0] sum;

   // Channel next state. Written as vector equations so every channel is
   // the same small gate network.
   always_comb begin
      q_d = q_q;
      if (en) begin
         unique case (mode)
            // s=r=1 holds: the set term is masked by r, the clear term by s.
            MODE_SR: q_d = (q_q | (s & ~r)) & ~(r & ~s);
            MODE_JK: q_d = (s & ~q_q) | (~r & q_q);
            MODE_D:  q_d = s;
            MODE_T:  q_d = q_q ^ s;
            default: q_d = q_q;
         endcase
      end
   end

   // Forbidden events only exist in enabled SR mode.
   always_comb begin
      forbid = '0;
      if (en && (mode == MODE_SR)) begin
         forbid = s & r;
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + 6'(forbid[i]);
      end
   end

   // clr_err wipes the old state first, so an event in the same cycle is
   // still recorded on top of the cleared value.
   always_comb begin
      err_base = clr_err ? '0 : err_q;
      cnt_base = clr_err ? '0 : cnt_q;
      err_d    = err_base | forbid;
      sum      = SUM_W'(cnt_base) + SUM_W'(pop);
      cnt_d    = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q   <= '0;
         err_q <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign q       = q_q;
   assign q_bar   = ~q_q;  // derived from the register, so it can never disagree with q
   assign err     = err_q;
   assign err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_bank
//
// Bench for sr_ff_bank with WIDTH=4, CNT_W=4. A vector table holds the
// directed scenarios with hand-derived expected values. A short randomized
// phase follows, checked against an independent behavioural model. Every
// driven cycle pushes its expected {q, q_bar, err, err_cnt} into a
// scoreboard queue, which is popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_sr_ff_bank;

   localparam int W  = 4;
   localparam int C  = 4;
   localparam int PW = 3 * W + C;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] s;
   logic [W-1:0] r;
   logic         clr_err;
   logic [W-1:0] q;
   logic [W-1:0] q_bar;
   logic [W-1:0] err;
   logic [C-1:0] err_cnt;

   always #5 clk = ~clk;

   sr_ff_bank #(.WIDTH(W), .CNT_W(C)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .s       (s),
      .r       (r),
      .clr_err (clr_err),
      .q       (q),
      .q_bar   (q_bar),
      .err     (err),
      .err_cnt (err_cnt)
   );

   // ---------------- scoreboard ----------------
   logic [PW-1:0] exp_q[$];
   int            chk_cnt  = 0;
   int            pass_cnt = 0;

   // Model state, kept equal to the last expected outputs.
   logic [W-1:0] mq;
   logic [W-1:0] merr;
   logic [C-1:0] mcnt;

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] expv);
      chk_cnt++;
      if (act === expv) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, expv);
      end
   endtask

   task automatic compare_out(input int idx);
      logic [PW-1:0] e;
      if (exp_q.size() == 0) begin
         chk_cnt++;
         $display("FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
      end else begin
         e = exp_q.pop_front();
         check("q",       idx, 32'(q),       32'(e[PW-1 -: W]));
         check("q_bar",   idx, 32'(q_bar),   32'(e[PW-W-1 -: W]));
         check("err",     idx, 32'(err),     32'(e[C+W-1 -: W]));
         check("err_cnt", idx, 32'(err_cnt), 32'(e[C-1:0]));
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input int idx, input logic rst_v, input logic en_v,
                        input logic [1:0] m, input logic [W-1:0] sv,
                        input logic [W-1:0] rv, input logic c,
                        input logic [W-1:0] eq, input logic [W-1:0] eerr,
                        input logic [C-1:0] ecnt);
      @(negedge clk);
      reset   = rst_v;
      en      = en_v;
      mode    = m;
      s       = sv;
      r       = rv;
      clr_err = c;
      exp_q.push_back({eq, ~eq, eerr, ecnt});
      mq   = eq;
      merr = eerr;
      mcnt = ecnt;
      @(posedge clk);
      #1;
      compare_out(idx);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         rst;
      logic         en;
      logic [1:0]   mode;
      logic [W-1:0] s;
      logic [W-1:0] r;
      logic         clr;
      logic [W-1:0] eq;
      logic [W-1:0] eerr;
      logic [C-1:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic en_v, logic [1:0] m,
                               logic [W-1:0] sv, logic [W-1:0] rv, logic c,
                               logic [W-1:0] eq, logic [W-1:0] eerr,
                               logic [C-1:0] ecnt);
      vec_t v;
      v.rst = rst; v.en = en_v; v.mode = m; v.s = sv; v.r = rv; v.clr = c;
      v.eq = eq; v.eerr = eerr; v.ecnt = ecnt;
      return v;
   endfunction

   // Reference next-state, written per bit from the mode truth tables.
   task automatic model_step(input logic rst_v, input logic en_v,
                             input logic [1:0] m, input logic [W-1:0] sv,
                             input logic [W-1:0] rv, input logic c,
                             output logic [W-1:0] nq, output logic [W-1:0] nerr,
                             output logic [C-1:0] ncnt);
      int cnt;
      nq   = mq;
      nerr = c ? '0 : merr;
      cnt  = c ? 0 : int'(mcnt);
      for (int i = 0; i < W; i++) begin
         if (en_v) begin
            case (m)
               2'b00: begin
                  if (sv[i] && !rv[i]) nq[i] = 1'b1;
                  else if (!sv[i] && rv[i]) nq[i] = 1'b0;
                  if (sv[i] && rv[i]) begin
                     nerr[i] = 1'b1;
                     cnt     = cnt + 1;
                  end
               end
               2'b01: begin
                  if (sv[i] && rv[i]) nq[i] = ~mq[i];
                  else if (sv[i]) nq[i] = 1'b1;
                  else if (rv[i]) nq[i] = 1'b0;
               end
               2'b10: nq[i] = sv[i];
               default: if (sv[i]) nq[i] = ~mq[i];
            endcase
         end
      end
      if (cnt > (1 << C) - 1) cnt = (1 << C) - 1;
      ncnt = C'(cnt);
      if (rst_v) begin
         nq = '0; nerr = '0; ncnt = '0;
      end
   endtask

   // ---------------- test ----------------
   initial begin
      logic [W-1:0] nq, nerr;
      logic [C-1:0] ncnt;
      logic         rr, ee, cc;
      logic [1:0]   mm;
      logic [W-1:0] ss, rv;

      reset = 1'b1; en = 1'b0; mode = 2'b00; s = '0; r = '0; clr_err = 1'b0;
      mq = '0; merr = '0; mcnt = '0;

      // reset, then hold with en=0
      tbl.push_back(mk(1, 0, 2'b00, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1, 0, 2'b00, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, 2'b00, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0));
      // SR sequence on channel 0
      tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h1, 0, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(0, 1, 2'b00, 4'h1, 4'h1, 0, 4'h0, 4'h1, 4'h1));
      tbl.push_back(mk(0, 1, 2'b00, 4'h1, 4'h0, 0, 4'h1, 4'h1, 4'h1));
      tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h0, 0, 4'h1, 4'h1, 4'h1));
      tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h1, 0, 4'h0, 4'h1, 4'h1));
      // JK with s=r=F: F, 0, F (no error counted)
      tbl.push_back(mk(0, 1, 2'b01, 4'hF, 4'hF, 0, 4'hF, 4'h1, 4'h1));
      tbl.push_back(mk(0, 1, 2'b01, 4'hF, 4'hF, 0, 4'h0, 4'h1, 4'h1));
      tbl.push_back(mk(0, 1, 2'b01, 4'hF, 4'hF, 0, 4'hF, 4'h1, 4'h1));
      // T with s=5: A, F
      tbl.push_back(mk(0, 1, 2'b11, 4'h5, 4'h0, 0, 4'hA, 4'h1, 4'h1));
      tbl.push_back(mk(0, 1, 2'b11, 4'h5, 4'h0, 0, 4'hF, 4'h1, 4'h1));
      // D mode (r ignored, no error), then en=0 holds
      tbl.push_back(mk(0, 1, 2'b10, 4'h9, 4'hF, 0, 4'h9, 4'h1, 4'h1));
      tbl.push_back(mk(0, 0, 2'b10, 4'h6, 4'h0, 0, 4'h9, 4'h1, 4'h1));
      // clr_err with en=0
      tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'h0, 1, 4'h9, 4'h0, 4'h0));
      // saturation: 4, 8, C, F, F
      tbl.push_back(mk(0, 1, 2'b00, 4'hF, 4'hF, 0, 4'h9, 4'hF, 4'h4));
      tbl.push_back(mk(0, 1, 2'b00, 4'hF, 4'hF, 0, 4'h9, 4'hF, 4'h8));
      tbl.push_back(mk(0, 1, 2'b00, 4'hF, 4'hF, 0, 4'h9, 4'hF, 4'hC));
      tbl.push_back(mk(0, 1, 2'b00, 4'hF, 4'hF, 0, 4'h9, 4'hF, 4'hF));
      tbl.push_back(mk(0, 1, 2'b00, 4'hF, 4'hF, 0, 4'h9, 4'hF, 4'hF));
      // clear and new event in the same cycle
      tbl.push_back(mk(0, 1, 2'b00, 4'h3, 4'h3, 1, 4'h9, 4'h3, 4'h2));
      // s=r=F in SR mode with en=0 is not an error
      tbl.push_back(mk(0, 0, 2'b00, 4'hF, 4'hF, 0, 4'h9, 4'h3, 4'h2));
      // T toggle with err set, then reset wins over en and toggle
      tbl.push_back(mk(0, 1, 2'b11, 4'hF, 4'h0, 0, 4'h6, 4'h3, 4'h2));
      tbl.push_back(mk(1, 1, 2'b11, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0));
      // reset also beats clr_err together with a forbidden event
      tbl.push_back(mk(0, 1, 2'b10, 4'h5, 4'hF, 0, 4'h5, 4'h0, 4'h0));
      tbl.push_back(mk(1, 1, 2'b00, 4'hF, 4'hF, 1, 4'h0, 4'h0, 4'h0));

      foreach (tbl[i]) begin
         drive(i, tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].s, tbl[i].r,
               tbl[i].clr, tbl[i].eq, tbl[i].eerr, tbl[i].ecnt);
      end

      // Hand sequence: saturate, then clear with no event drops to 0, and a
      // single-channel event after a clear counts exactly one.
      for (int i = 0; i < 4; i++) begin
         model_step(0, 1, 2'b00, 4'hF, 4'hF, 0, nq, nerr, ncnt);
         drive(100 + i, 0, 1, 2'b00, 4'hF, 4'hF, 0, nq, nerr, ncnt);
      end
      drive(104, 0, 1, 2'b00, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
      drive(105, 0, 1, 2'b00, 4'h4, 4'h4, 0, 4'h0, 4'h4, 4'h1);

      // Randomized phase against the reference model.
      for (int i = 0; i < 60; i++) begin
         rr = ($urandom_range(0, 24) == 0);
         ee = ($urandom_range(0, 3) != 0);
         cc = ($urandom_range(0, 9) == 0);
         mm = 2'($urandom_range(0, 3));
         ss = W'($urandom_range(0, (1 << W) - 1));
         rv = W'($urandom_range(0, (1 << W) - 1));
         model_step(rr, ee, mm, ss, rv, cc, nq, nerr, ncnt);
         drive(200 + i, rr, ee, mm, ss, rv, cc, nq, nerr, ncnt);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised, clocked successor to the single-bit SR latch: a bank of `WIDTH` edge-triggered flip-flops sharing one clock, with a run-time mode select (SR, JK, D, T) and a common enable. Each bank detects the SR forbidden input combination per channel, keeps a sticky flag for it, and counts such events. The block sits in the latch/flip-flop library and serves as the state-holding element for small controllers such as the traffic light controller.

## Interface
Parameters:
- `WIDTH`, 4: number of flip-flop channels, from 1 to 32.
- `CNT_W`, 8: width of the forbidden-event counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  update enable. When `en`=0, all channel state holds.
- `mode`  in  2  00=SR, 01=JK, 10=D, 11=T. Applies to all channels.
- `s`  in  WIDTH  per-channel S, J, D or T input, depending on mode.
- `r`  in  WIDTH  per-channel R or K input. Ignored in D and T modes.
- `clr_err`  in  1  clears `err` and `err_cnt`.
- `q`  out  WIDTH  channel state.
- `q_bar`  out  WIDTH  always equal to ~`q`. There is no q=q_bar state, unlike the latch.
- `err`  out  WIDTH  sticky per-channel flag for the SR forbidden input.
- `err_cnt`  out  CNT_W  saturating count of forbidden events.

## Operation
- The only state is `q`, `err` and `err_cnt`. All of it updates on the rising edge of `clk`.
- Priority, highest first: `reset`, then `en`=0 (hold), then the mode function.
- Per-channel next state when `en`=1. Notation is (s,r) → next `q`:
  - SR mode: 00 hold, 01 clear to 0, 10 set to 1, 11 hold and count as a forbidden event.
  - JK mode: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
  - D mode: next `q` = `s`.
  - T mode: toggle when `s`=1, hold when `s`=0.
- Forbidden events are counted only when `en`=1 and `mode`=00. `s`=`r`=1 in any other mode, or with `en`=0, is not an error.
- `err[i]` is set on the edge where channel i sees a forbidden event. It stays set until `clr_err` or `reset`.
- `err_cnt` adds popcount(s & r) each qualifying cycle and saturates at 2^CNT_W−1. It never wraps.
- If `clr_err` and a forbidden event occur in the same cycle, the clear applies first and the new event is then recorded:
  - `err` = s & r for that cycle.
  - `err_cnt` = popcount(s & r).
- `clr_err` works independently of `en`.
- A `mode` change takes effect on the same edge it is sampled. No pipeline.

## Timing
- Reset values, visible after the first rising edge with `reset`=1:
  - `q` = 0.
  - `q_bar` = all ones.
  - `err` = 0.
  - `err_cnt` = 0.
- `reset` takes priority over every other input, including an in-flight toggle or `clr_err`.
- Latency: inputs sampled at edge N appear on `q`, `q_bar`, `err` and `err_cnt` after edge N. One cycle, no combinational input-to-output path.
- `q_bar` is registered or derived from registered `q`. It must never glitch relative to `q` at a clock edge.
- Behaviour before the first reset is undefined. The bench must assert `reset` for at least one edge.

## Test plan
- Reset and hold (`WIDTH`=4):
  - Stimulus: `reset`=1 for 2 cycles, then `en`=0 with `s`=F, `r`=0 for 3 cycles.
  - Required: `q`=0, `q_bar`=F and `err_cnt`=0 throughout.
- SR sequence on channel 0, `mode`=00, `en`=1:
  - Stimulus: (s,r) = 00, 01, 11, 10, 00, 01, one per cycle.
  - Required: `q[0]` = 0, 0, 0, 1, 1, 0.
  - Required: `err[0]` goes to 1 after the third edge; `err_cnt`=1.
- JK and T modes:
  - Stimulus: JK with s=r=F for 3 cycles.
  - Required: `q` = F, 0, F.
  - Stimulus: switch to T with `s`=5 for 2 cycles.
  - Required: `q` = A, then F.
- D mode and `en` gating:
  - Stimulus: `s`=9, then `en`=0 with `s`=6.
  - Required: `q`=9 and stays 9; `q_bar`=6.
- Counter saturation and clear (`CNT_W`=4):
  - Stimulus: SR mode with s=r=F for 5 cycles.
  - Required: `err_cnt` = 4, 8, C, F, F and `err`=F.
  - Stimulus: `clr_err`=1 together with s=r=3.
  - Required: `err`=3, `err_cnt`=2.
- Reset mid-operation:
  - Stimulus: T mode toggling with `err`≠0, then `reset`=1 together with `clr_err`=0 and `en`=1.
  - Required: all outputs return to their reset values after that edge.
